vreg_write_sequencer: RTL
=========================

Name: vreg_write_sequencer

Overview:
- Sequences vector-instruction results into the vector register file, one WIDTH-bit beat at a time.
- Walks the destination register chunk by chunk and generates per-byte write flags from vl, SEW and the v0 mask.
- Drives the register file's write-side inputs: result, update_vreg/update_mask, write flags and destination address.
- Sits between the vector ALU result stream and the register file.

Parameters:
- WIDTH, 32: beat/result width in bits; must be 32.
- VLEN, 128: vector register length in bits; multiple of WIDTH.
- NREG, 32: number of architectural vector registers.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  start request; accepted only when o_ready=1
- o_ready  out  1  idle, can accept i_start
- i_vd  in  $clog2(NREG)  destination register
- i_vl  in  $clog2(VLEN/8)+1  element count
- i_sew  in  2  0=8b, 1=16b, 2=32b, 3=reserved (treated as 32b)
- i_vm  in  1  1=unmasked, 0=masked by v0
- i_mask  in  VLEN  current v0 contents
- i_res_valid  in  1  result beat valid
- o_res_ready  out  1  sequencer accepts beat
- i_res_data  in  WIDTH  result beat
- o_ALU_result  out  WIDTH  data to register file
- o_update_vreg  out  1  write strobe, vd!=0
- o_update_mask  out  1  write strobe, vd==0
- o_Vreg_write_flag  out  VLEN/8  per-byte write enables
- o_Vregs_input_adr  out  $clog2(NREG)  write address
- o_busy  out  1  operation in flight
- o_done  out  1  one-cycle completion pulse
- o_stall_cycles  out  32  see Optional Feature

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; o_ready=1.
  - All other outputs 0, including o_stall_cycles.
  - Internal beat counter 0; no write strobes.
- States:
  - IDLE: o_ready=1, o_busy=0, o_res_ready=0.
  - WRITE: o_busy=1, o_res_ready=1.
  - DONE: o_busy=1, o_done=1 for exactly one cycle.
- IDLE→WRITE on i_start. Latch vd, sew, vm, a snapshot of i_mask, and vl_eff = min(i_vl, VLEN/(8<<sew_eff)). Clear the beat counter k.
- IDLE→DONE on i_start with vl_eff==0. No writes are issued.
- Beat count: nbeats = ceil(vl_eff*(1<<sew_eff)/4).
- Beat k occupies bytes 4k..4k+3. For byte b=4k+j:
  - element e = b>>sew_eff;
  - flag[b] = (e<vl_eff) & (vm | mask_snap[e]);
  - all flags outside bytes 4k..4k+3 are 0.
- Tail and masked-off bytes get flag 0 (undisturbed).
- Handshake: a beat transfers when i_res_valid & o_res_ready. The cycle after the transfer is registered:
  - o_ALU_result = beat data;
  - o_Vreg_write_flag set per the rule above;
  - o_Vregs_input_adr = vd;
  - o_update_mask=1 if vd==0, else o_update_vreg=1.
- The strobe is held for one cycle, then the strobes and flags return to 0. o_ALU_result and the address hold their last value.
- A fully masked beat must still be consumed. Its strobe is asserted with flags=0.
- k increments per transfer. WRITE→DONE on the transfer where k==nbeats-1.
- DONE→IDLE unconditionally. Write latency is 1 cycle. The last write strobe coincides with o_done.
- i_start while o_ready=0 is ignored. i_res_valid outside WRITE is ignored.
- The mask snapshot is taken at start. A write to v0 during the operation does not alter the flags of the current operation.
- Back-to-back: a new i_start is accepted in the cycle after DONE (IDLE).
- Reset mid-operation immediately aborts. No further strobes; any partially written register is left as is.

Optional Feature:
- Macro VREG_SEQ_PERF_EN.
- Defined: o_stall_cycles counts WRITE cycles with i_res_valid=0. Saturates at 2^32-1. Cleared only by reset.
- Undefined: o_stall_cycles tied to 0 and no counter logic is instantiated. All other behaviour is identical.

Test Plan:
- Unmasked, sew=2, vl=4, vd=3. Beats 0xA0A0A0A0..0xD3D3D3D3, valid every cycle →
  - 4 strobes with o_update_vreg=1, adr=3;
  - flags 0x000F, 0x00F0, 0x0F00, 0xF000;
  - o_done on cycle 5 after start.
- Masked, sew=0, vl=6, vm=0, mask=0b101101, vd=5 →
  - 2 beats, flags 0x000D then 0x0020;
  - o_done with the second strobe.
- Clamp and tail:
  - sew=1, vl=20 (clamped to 8) → 4 beats, each flag nibble 0xF.
  - sew=1, vl=3 → 2 beats, flags 0x000F, 0x0030.
- vl=0 with i_start → no strobes; o_done one cycle after start; o_ready again the next cycle.
- vd=0, unmasked, sew=2, vl=4 → o_update_mask=1 and o_update_vreg=0 on all 4 strobes. Changing i_mask mid-op has no effect on flags.
- Stalls and reset:
  - Insert 3 idle cycles between beats 1 and 2 → o_stall_cycles=3 with VREG_SEQ_PERF_EN, 0 without.
  - Assert i_rst_n=0 after beat 2 → outputs 0 asynchronously, no further strobes, o_ready=1 after release.

Source files
------------

// File: rtl/vreg_write_sequencer.sv
// Streams WIDTH-bit result beats into one vector register, generating per-byte write enables from vl, SEW and v0.
// Optional stall-cycle counter is enabled by defining VREG_SEQ_PERF_EN.
module vreg_write_sequencer #(
  parameter int WIDTH = 32,
  parameter int VLEN  = 128,
  parameter int NREG  = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  output logic                       o_ready,
  input  logic [$clog2(NREG)-1:0]    i_vd,
  input  logic [$clog2(VLEN/8):0]    i_vl,
  input  logic [1:0]                 i_sew,
  input  logic                       i_vm,
  input  logic [VLEN-1:0]            i_mask,
  input  logic                       i_res_valid,
  output logic                       o_res_ready,
  input  logic [WIDTH-1:0]           i_res_data,
  output logic [WIDTH-1:0]           o_ALU_result,
  output logic                       o_update_vreg,
  output logic                       o_update_mask,
  output logic [VLEN/8-1:0]          o_Vreg_write_flag,
  output logic [$clog2(NREG)-1:0]    o_Vregs_input_adr,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [31:0]                o_stall_cycles
);

  localparam int NBYTES = VLEN / 8;
  localparam int BPB    = WIDTH / 8;
  localparam int NBEATS = VLEN / WIDTH;
  localparam int VDW    = $clog2(NREG);
  localparam int VLW    = $clog2(NBYTES) + 1;
  localparam int KW     = $clog2(NBEATS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t state, state_nxt;

  logic [VDW-1:0]    vd_q;
  logic [1:0]        sew_q;
  logic              vm_q;
  logic [NBYTES-1:0] mask_q;
  logic [VLW-1:0]    vl_eff_q;
  logic [KW-1:0]     nbeats_q;
  logic [KW-1:0]     k;

  logic [1:0]        sew_in;
  logic [VLW-1:0]    max_el;
  logic [VLW-1:0]    vl_eff_in;
  logic [VLW-1:0]    bytes_in;
  logic [VLW-1:0]    beats_w;
  logic [KW-1:0]     nbeats_in;

  logic              xfer;
  logic              last_beat;
  logic              start_acc;
  logic [NBYTES-1:0] elem_en;
  logic [NBYTES-1:0] flag_nxt;

  // Only the first NBYTES mask bits can ever select an element (SEW=8 maximum count).
  logic unused_mask_hi;
  assign unused_mask_hi = ^i_mask[VLEN-1:NBYTES];

  // Reserved SEW encoding behaves as 32-bit elements.
  always_comb begin
    sew_in    = (i_sew == 2'd3) ? 2'd2 : i_sew;
    max_el    = VLW'(NBYTES) >> sew_in;
    vl_eff_in = (i_vl > max_el) ? max_el : i_vl;
    bytes_in  = vl_eff_in << sew_in;
    beats_w   = (bytes_in + VLW'(BPB - 1)) >> $clog2(BPB);
    nbeats_in = KW'(beats_w);
  end

  assign start_acc = (state == S_IDLE) && i_start;
  assign xfer      = (state == S_WRITE) && i_res_valid;
  assign last_beat = (k == nbeats_q - KW'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    o_ready     = 1'b0;
    o_busy      = 1'b0;
    o_res_ready = 1'b0;
    o_done      = 1'b0;
    case (state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          state_nxt = (vl_eff_in == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        o_busy      = 1'b1;
        o_res_ready = 1'b1;
        if (i_res_valid && last_beat) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_busy    = 1'b1;
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operation context is frozen at start so later v0 writes cannot disturb this operation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vd_q     <= '0;
      sew_q    <= '0;
      vm_q     <= 1'b0;
      mask_q   <= '0;
      vl_eff_q <= '0;
      nbeats_q <= '0;
      k        <= '0;
    end else if (start_acc) begin
      vd_q     <= i_vd;
      sew_q    <= sew_in;
      vm_q     <= i_vm;
      mask_q   <= i_mask[NBYTES-1:0];
      vl_eff_q <= vl_eff_in;
      nbeats_q <= nbeats_in;
      k        <= '0;
    end else if (xfer) begin
      k <= k + KW'(1);
    end
  end

  for (genvar e = 0; e < NBYTES; e++) begin : g_elem
    assign elem_en[e] = (VLW'(e) < vl_eff_q) && (vm_q || mask_q[e]);
  end

  // Each byte maps to a fixed element index per SEW, so the selection stays constant-indexed.
  for (genvar b = 0; b < NBYTES; b++) begin : g_byte
    logic sel;
    always_comb begin
      case (sew_q)
        2'd0:    sel = elem_en[b];
        2'd1:    sel = elem_en[b/2];
        default: sel = elem_en[b/4];
      endcase
    end
    assign flag_nxt[b] = sel && (k == KW'(b / BPB));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ALU_result      <= '0;
      o_Vreg_write_flag <= '0;
      o_Vregs_input_adr <= '0;
      o_update_vreg     <= 1'b0;
      o_update_mask     <= 1'b0;
    end else if (xfer) begin
      o_ALU_result      <= i_res_data;
      o_Vreg_write_flag <= flag_nxt;
      o_Vregs_input_adr <= vd_q;
      o_update_vreg     <= (vd_q != '0);
      o_update_mask     <= (vd_q == '0);
    end else begin
      o_Vreg_write_flag <= '0;
      o_update_vreg     <= 1'b0;
      o_update_mask     <= 1'b0;
    end
  end

`ifdef VREG_SEQ_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_q <= '0;
    end else if ((state == S_WRITE) && !i_res_valid && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign o_stall_cycles = stall_q;
`else
  assign o_stall_cycles = 32'd0;
`endif

endmodule
